// File: rtl/shift_left_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_left_seq
// Description : Multi-cycle logical left shifter. It is built as a five-stage
//               log shifter that runs one stage per clock. When a start
//               request is accepted in IDLE, the operands are latched. Stage k
//               shifts by 2^k when bit k of the latched shift amount is set.
//               A function code other than 6'b000000 selects pass-through:
//               the shift amount is forced to zero and the operand is returned
//               unchanged.
//
// Ports       : clk     in   1   clock, rising edge
//               reset   in   1   synchronous, active-high reset
//               start   in   1   request, only sampled in IDLE
//               Signal  in   6   function code (6'b000000 = SLL)
//               a       in  32   operand data
//               shamt   in   5   shift amount 0..31
//               busy    out  1   high while SHIFT or DONE
//               done    out  1   one-cycle completion pulse
//               result  out 32   shifted data, held until next accepted start
//
// Config      : SHL_EARLY_DONE_EN -- when defined, the FSM leaves SHIFT as
//               soon as no higher shift-amount bits remain set. Otherwise
//               every operation takes a fixed five stages.
//
// Revision    : 1.0 - initial release
// ============================================================================
module shift_left_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  Signal,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [5:0] c_FUNC_SLL   = 6'b000000;
    localparam logic [2:0] c_LAST_STAGE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_result;
    logic [4:0]  r_shamt;
    logic [2:0]  r_stage;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_shifted;
    logic [2:0]  w_next_stage;
    logic [4:0]  w_shamt_rem;
    logic        w_stage_en;
    logic        w_last;

    // Shift by 2^k for the current stage. Bits leaving bit 31 are dropped.
    always_comb begin
        w_shifted = r_result;
        case (r_stage)
            3'd0:    w_shifted = r_result << 1;
            3'd1:    w_shifted = r_result << 2;
            3'd2:    w_shifted = r_result << 4;
            3'd3:    w_shifted = r_result << 8;
            3'd4:    w_shifted = r_result << 16;
            default: w_shifted = r_result;
        endcase
    end

    assign w_next_stage = r_stage + 3'd1;
    // Bit 0 of the remaining amount is the enable for the current stage.
    assign w_shamt_rem  = r_shamt >> r_stage;
    assign w_stage_en   = w_shamt_rem[0];

`ifdef SHL_EARLY_DONE_EN
    // Finish once no set bits remain above the stage just processed. Stage 4
    // always satisfies this because shifting a 5-bit value by 5 yields zero.
    assign w_last = ((r_shamt >> w_next_stage) == 5'd0);
`else
    assign w_last = (r_stage == c_LAST_STAGE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_result <= 32'h0;
            r_shamt  <= 5'd0;
            r_stage  <= 3'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_result <= a;
                        // Only the effective amount is kept. In pass-through
                        // mode it is zero, so every stage holds the data.
                        r_shamt  <= (Signal == c_FUNC_SLL) ? shamt : 5'd0;
                        r_stage  <= 3'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_stage_en) begin
                        r_result <= w_shifted;
                    end
                    r_stage <= w_next_stage;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A start seen here is deliberately dropped.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: doc/shift_left_seq.md
SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

Interface
REQ-001 Ports SHALL be, one per line: name  direction  width  meaning.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 Signal  input  6  function code; 6'b000000 = SLL, any other value = pass-through.
REQ-006 a  input  32  operand data.
REQ-007 shamt  input  5  shift amount, 0-31.
REQ-008 busy  output  1  high in SHIFT and DONE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  32  shifted data; valid while done=1, then held until the next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 at edge N SHALL latch a into result, and latch Signal and shamt, set stage counter to 0, and enter SHIFT.
REQ-013 If the latched Signal is not 6'b000000, the latched shamt SHALL be forced to 0, so result equals a.
REQ-014 SHIFT SHALL process one stage k per edge: if shamt[k]=1, result <= result << 2^k with zero fill; otherwise result is held; then k increments.
REQ-015 After stage 4 (edge N+5), the FSM SHALL enter DONE, so done=1 during the cycle after edge N+5.
REQ-016 DONE SHALL return to IDLE on the next edge, with done deasserted.
REQ-017 Bits shifted past bit 31 SHALL be discarded; no overflow flag SHALL be produced.
REQ-018 start while busy=1 SHALL be ignored, with no queuing.
REQ-019 start=1 in the DONE cycle SHALL be ignored; the earliest accepted restart is the first IDLE cycle.
REQ-020 Changes to a, shamt or Signal after acceptance SHALL NOT affect the operation in progress.
REQ-021 The final result SHALL equal (a << shamt) modulo 2^32 for SLL, or a otherwise.

Reset
REQ-022 While reset=1 at an edge, state SHALL be IDLE, result 32'h0, busy 0, done 0, and the stage counter 0.
REQ-023 Reset SHALL take priority over start.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation, and no done pulse SHALL follow.
REQ-025 start sampled in the first cycle after reset deassertion SHALL be accepted.

Configuration
REQ-026 Macro SHL_EARLY_DONE_EN SHALL select the completion rule.
REQ-027 With SHL_EARLY_DONE_EN defined, after processing stage k, if the latched shamt[4:k+1] is all zero (always true for k=4), the FSM SHALL enter DONE on that edge; latency is (index of the highest set shamt bit + 1) edges after acceptance, minimum 1 (shamt=0 or pass-through).
REQ-028 Without SHL_EARLY_DONE_EN, latency SHALL be a fixed 5 edges after acceptance for all inputs.
REQ-029 Result values SHALL be identical in both builds; only done timing differs.

Verification
REQ-030 Bench: a=32'h0000_0001, shamt=31, Signal=0 -> result=32'h8000_0000; done 5 edges after acceptance in both builds.
REQ-031 Bench: a=32'hFFFF_FFFF, shamt=4, Signal=0 -> result=32'hFFFF_FFF0; done after 5 edges (default build) or 3 edges (SHL_EARLY_DONE_EN).
REQ-032 Bench: a=32'h1234_5678, shamt=8, Signal=6'b000010 -> result=32'h1234_5678; done after 5 edges (default build) or 1 edge (SHL_EARLY_DONE_EN).
REQ-033 Bench: start a=32'h1, shamt=1, then start pulsed again at acceptance+2 with a=32'h2 -> second start ignored; result=32'h2 from the first operation only.
REQ-034 Bench: reset asserted at acceptance+3 -> result=0, busy=0, no done pulse; start in the first cycle after reset release with a=32'h3, shamt=2 -> result=32'hC.
REQ-035 Bench: 1000 random (a, shamt, Signal) back-to-back operations -> every result matches REQ-021, and busy/done timing matches REQ-015/REQ-027 for the active build.
